// File: rtl/io_arbiter_if.sv
// io_arbiter_if: bundle of both master command ports, the shared IO controller
// port and the arbiter status signals.
// Optional lock inputs exist only when IO_ARB_LOCK_EN is defined.
interface io_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    // Master side: requests and commands
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
`ifdef IO_ARB_LOCK_EN
    logic              lock0;
    logic              lock1;
`endif

    // Master side: completions
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata;
    logic              busy;

    // IO controller side
    logic [ADDR_W-1:0] io_readaddr;
    logic [ADDR_W-1:0] io_writeaddr;
    logic [DATA_W-1:0] io_writedata;
    logic              io_write_en;
    logic [DATA_W-1:0] io_readdata;

    // Arbiter view
    modport slave (
`ifdef IO_ARB_LOCK_EN
        input  lock0, lock1,
`endif
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  io_readdata,
        output ack0, ack1, rdata, busy,
        output io_readaddr, io_writeaddr, io_writedata, io_write_en
    );

    // Masters plus IO controller view
    modport master (
`ifdef IO_ARB_LOCK_EN
        output lock0, lock1,
`endif
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output io_readdata,
        input  ack0, ack1, rdata, busy,
        input  io_readaddr, io_writeaddr, io_writedata, io_write_en
    );
endinterface

// File: rtl/io_arbiter.sv
// io_arbiter: round-robin arbiter sharing the single IO register port between
// the CPU (port 0) and an auxiliary master (port 1). One transaction in flight;
// each master gets a one-cycle ack, read data is returned on ack.
// Optional feature macro: IO_ARB_LOCK_EN (lock0/lock1 for atomic sequences).
module io_arbiter #(
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 8,
    parameter int READ_LAT = 1   // legal range 1..7
) (
    input  logic          clk,
    input  logic          reset,   // asynchronous, active low
    io_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int CNT_W = 3;

    if (READ_LAT < 1 || READ_LAT > 7) begin : g_bad_read_lat
        $error("io_arbiter: READ_LAT must be within 1..7");
    end

    state_t             state;
    state_t             next_state;
    logic               grant;
    logic               grant_port;
    logic               req0_eff;
    logic               req1_eff;

    logic               sel;
    logic               cmd_we;
    logic [ADDR_W-1:0]  cmd_addr;
    logic [DATA_W-1:0]  cmd_wdata;
    logic               rr_last;
    logic [CNT_W-1:0]   wait_cnt;
    logic [DATA_W-1:0]  rdata_q;

`ifdef IO_ARB_LOCK_EN
    logic               cmd_lock;
    logic               lock_active;
    logic               lock_port;

    // While a lock is held only the locking port may be granted
    always_comb begin
        req0_eff = bus.req0 && !(lock_active && lock_port);
        req1_eff = bus.req1 && !(lock_active && !lock_port);
    end
`else
    // Without locking both requests compete freely
    always_comb begin
        req0_eff = bus.req0;
        req1_eff = bus.req1;
    end
`endif

    // Next-state decode and grant selection
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        next_state = state;
        grant      = 1'b0;
        grant_port = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0_eff && req1_eff) begin
                    grant      = 1'b1;
                    grant_port = ~rr_last;
                end else if (req0_eff) begin
                    grant      = 1'b1;
                    grant_port = 1'b0;
                end else if (req1_eff) begin
                    grant      = 1'b1;
                    grant_port = 1'b1;
                end
                if (grant) next_state = ISSUE;
            end
            ISSUE:   next_state = cmd_we ? RESP : WAIT;
            WAIT:    if (wait_cnt == CNT_W'(1)) next_state = RESP;
            RESP:    next_state = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (!reset) state <= IDLE;
        else        state <= next_state;
    end

    // Command registers, latched from the winning port at grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sel       <= 1'b0;
            cmd_we    <= 1'b0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
        end else if (grant) begin
            sel       <= grant_port;
            cmd_we    <= grant_port ? bus.we1    : bus.we0;
            cmd_addr  <= grant_port ? bus.addr1  : bus.addr0;
            cmd_wdata <= grant_port ? bus.wdata1 : bus.wdata0;
        end
    end

    // Read latency counter: loaded in ISSUE, counts down through WAIT
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state == ISSUE && !cmd_we) begin
            wait_cnt <= CNT_W'(READ_LAT);
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
        end
    end

    // Read data capture in the last WAIT cycle; writes never touch it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                    rdata_q <= '0;
        else if (state == WAIT && wait_cnt == CNT_W'(1)) rdata_q <= bus.io_readdata;
    end

    // Round-robin pointer: remembers the last port that completed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              rr_last <= 1'b1;
        else if (state == RESP)  rr_last <= sel;
    end

`ifdef IO_ARB_LOCK_EN
    // Lock flag latched with the command; applied when the transaction completes
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cmd_lock    <= 1'b0;
            lock_active <= 1'b0;
            lock_port   <= 1'b0;
        end else begin
            if (grant) cmd_lock <= grant_port ? bus.lock1 : bus.lock0;
            if (state == RESP) begin
                lock_active <= cmd_lock;
                lock_port   <= sel;
            end
        end
    end
`endif

    // Outputs decoded from registered state and command registers only
    always_comb begin
        bus.ack0         = (state == RESP) && !sel;
        bus.ack1         = (state == RESP) &&  sel;
        bus.busy         = (state != IDLE);
        bus.io_write_en  = (state == ISSUE) && cmd_we;
        bus.io_readaddr  = cmd_addr;
        bus.io_writeaddr = cmd_addr;
        bus.io_writedata = cmd_wdata;
        bus.rdata        = rdata_q;
    end

endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: directed self-checking bench for io_arbiter.
// Instance u_dut1 uses READ_LAT=1, u_dut3 uses READ_LAT=3.
// Lock tests are compiled in when IO_ARB_LOCK_EN is defined.
module tb_io_arbiter;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    bit   mon_en;

    io_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus1 ();
    io_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus3 ();

    io_arbiter #(.ADDR_W(5), .DATA_W(8), .READ_LAT(1)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.slave)
    );

    io_arbiter #(.ADDR_W(5), .DATA_W(8), .READ_LAT(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus3.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Continuous invariants on the READ_LAT=1 instance
    always @(negedge clk) begin
        if (mon_en) begin
            check("ack_exclusive", 32'(bus1.ack0 & bus1.ack1), 32'd0);
            check("we_while_busy", 32'(bus1.io_write_en & ~bus1.busy), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        reset    = 1'b0;
        bus1.req0 = 0; bus1.req1 = 0; bus1.we0 = 0; bus1.we1 = 0;
        bus1.addr0 = 0; bus1.addr1 = 0; bus1.wdata0 = 0; bus1.wdata1 = 0;
        bus1.io_readdata = 8'hEE;
        bus3.req0 = 0; bus3.req1 = 0; bus3.we0 = 0; bus3.we1 = 0;
        bus3.addr0 = 0; bus3.addr1 = 0; bus3.wdata0 = 0; bus3.wdata1 = 0;
        bus3.io_readdata = 8'hEE;
`ifdef IO_ARB_LOCK_EN
        bus1.lock0 = 0; bus1.lock1 = 0;
        bus3.lock0 = 0; bus3.lock1 = 0;
`endif
        tick();
        tick();

        // Reset state: all outputs zero
        check("rst_busy",  32'(bus1.busy), 32'd0);
        check("rst_acks",  32'({bus1.ack0, bus1.ack1}), 32'd0);
        check("rst_wen",   32'(bus1.io_write_en), 32'd0);
        check("rst_rdata", 32'(bus1.rdata), 32'd0);
        check("rst_waddr", 32'(bus1.io_writeaddr), 32'd0);
        check("rst_wdata", 32'(bus1.io_writedata), 32'd0);

        reset  = 1'b1;
        mon_en = 1'b1;
        tick();

        // Test 1: port 0 read addr 0, READ_LAT=1, data valid in cycle +2 only
        bus1.req0 = 1; bus1.we0 = 0; bus1.addr0 = 5'd0;
        tick();                                    // cycle +1
        check("rd1_busy",   32'(bus1.busy), 32'd1);
        check("rd1_wen",    32'(bus1.io_write_en), 32'd0);
        check("rd1_raddr",  32'(bus1.io_readaddr), 32'd0);
        tick();                                    // cycle +2
        bus1.io_readdata = 8'hA5;
        check("rd1_ack_early", 32'(bus1.ack0), 32'd0);
        tick();                                    // cycle +3
        bus1.io_readdata = 8'hEE;
        check("rd1_ack0",   32'(bus1.ack0), 32'd1);
        check("rd1_ack1",   32'(bus1.ack1), 32'd0);
        check("rd1_rdata",  32'(bus1.rdata), 32'hA5);
        bus1.req0 = 0;
        tick();
        check("rd1_idle",   32'(bus1.busy), 32'd0);
        check("rd1_ackoff", 32'(bus1.ack0), 32'd0);

        // Test 2: port 1 write addr 1 data 0C
        bus1.req1 = 1; bus1.we1 = 1; bus1.addr1 = 5'd1; bus1.wdata1 = 8'h0C;
        tick();                                    // cycle +1
        check("wr1_wen",    32'(bus1.io_write_en), 32'd1);
        check("wr1_waddr",  32'(bus1.io_writeaddr), 32'd1);
        check("wr1_wdata",  32'(bus1.io_writedata), 32'h0C);
        check("wr1_ack1_early", 32'(bus1.ack1), 32'd0);
        tick();                                    // cycle +2
        check("wr1_wen_off", 32'(bus1.io_write_en), 32'd0);
        check("wr1_ack1",   32'(bus1.ack1), 32'd1);
        check("wr1_ack0",   32'(bus1.ack0), 32'd0);
        check("wr1_rdata",  32'(bus1.rdata), 32'hA5);
        bus1.req1 = 0;
        tick();
        check("wr1_hold_addr", 32'(bus1.io_writeaddr), 32'd1);
        check("wr1_hold_data", 32'(bus1.io_writedata), 32'h0C);

        // Test 3: both ports held, writes 1,2,3,4 -> grant order 0,1,0,1
        bus1.req0 = 1; bus1.we0 = 1; bus1.addr0 = 5'd2; bus1.wdata0 = 8'h01;
        bus1.req1 = 1; bus1.we1 = 1; bus1.addr1 = 5'd3; bus1.wdata1 = 8'h02;
        for (int k = 0; k < 4; k++) begin
            bit seen;
            seen = 1'b0;
            for (int c = 0; c < 8 && !seen; c++) begin
                tick();
                if (bus1.ack0 || bus1.ack1) seen = 1'b1;
            end
            check("rr_ack_seen", 32'(seen), 32'd1);
            if (seen) begin
                check("rr_port", 32'(bus1.ack1), 32'(k % 2));
                check("rr_data", 32'(bus1.io_writedata), 32'(k + 1));
                if (bus1.ack0) bus1.wdata0 = bus1.wdata0 + 8'd2;
                else           bus1.wdata1 = bus1.wdata1 + 8'd2;
            end
        end
        bus1.req0 = 0; bus1.req1 = 0;
        tick();
        check("rr_idle", 32'(bus1.busy), 32'd0);

        // Test 4: port 0 completes (rr_last=0), then reset during port 1 ISSUE
        bus1.req0 = 1; bus1.we0 = 1; bus1.addr0 = 5'd4; bus1.wdata0 = 8'h55;
        tick();
        tick();
        check("pre_ack0", 32'(bus1.ack0), 32'd1);
        bus1.req0 = 0;
        tick();
        bus1.req1 = 1; bus1.we1 = 1; bus1.addr1 = 5'd5; bus1.wdata1 = 8'h66;
        tick();                                    // ISSUE of port 1 write
        check("abort_wen_before", 32'(bus1.io_write_en), 32'd1);
        #1 reset = 1'b0;
        #1;
        check("abort_wen",  32'(bus1.io_write_en), 32'd0);
        check("abort_busy", 32'(bus1.busy), 32'd0);
        check("abort_ack",  32'({bus1.ack0, bus1.ack1}), 32'd0);
        check("abort_wdata", 32'(bus1.io_writedata), 32'd0);
        bus1.req0 = 1; bus1.we0 = 1; bus1.addr0 = 5'd6; bus1.wdata0 = 8'h77;
        tick();
        check("abort_no_ack", 32'({bus1.ack0, bus1.ack1}), 32'd0);
        reset = 1'b1;                              // released in cycle c0, both requesting
        tick();                                    // cycle +1
        check("tie_wen",   32'(bus1.io_write_en), 32'd1);
        check("tie_wdata", 32'(bus1.io_writedata), 32'h77);
        tick();                                    // cycle +2
        check("tie_ack0",  32'(bus1.ack0), 32'd1);
        bus1.req0 = 0; bus1.req1 = 0;
        tick();

        // Test 5: READ_LAT=3 instance, data valid in cycle +4 only
        bus3.req0 = 1; bus3.we0 = 0; bus3.addr0 = 5'd0;
        tick();                                    // +1
        check("rd3_busy", 32'(bus3.busy), 32'd1);
        tick();                                    // +2
        tick();                                    // +3
        check("rd3_ack_early", 32'(bus3.ack0), 32'd0);
        tick();                                    // +4
        bus3.io_readdata = 8'h3C;
        check("rd3_ack_early4", 32'(bus3.ack0), 32'd0);
        tick();                                    // +5
        bus3.io_readdata = 8'hEE;
        check("rd3_ack0",  32'(bus3.ack0), 32'd1);
        check("rd3_rdata", 32'(bus3.rdata), 32'h3C);
        bus3.req0 = 0;
        tick();
        check("rd3_idle",  32'(bus3.busy), 32'd0);

`ifdef IO_ARB_LOCK_EN
        // Test 6: port 0 locked read, port 1 blocked until unlocking write
        bus1.req0 = 1; bus1.we0 = 0; bus1.addr0 = 5'd2; bus1.lock0 = 1;
        tick();                                    // +1
        tick();                                    // +2
        bus1.io_readdata = 8'h5A;
        tick();                                    // +3
        bus1.io_readdata = 8'hEE;
        check("lk_ack0",  32'(bus1.ack0), 32'd1);
        check("lk_rdata", 32'(bus1.rdata), 32'h5A);
        bus1.req0 = 0;
        bus1.req1 = 1; bus1.we1 = 1; bus1.addr1 = 5'd7; bus1.wdata1 = 8'h99; bus1.lock1 = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("lk_blocked", 32'(bus1.busy), 32'd0);
        end
        bus1.req0 = 1; bus1.we0 = 1; bus1.addr0 = 5'd1; bus1.wdata0 = 8'h0F; bus1.lock0 = 0;
        tick();                                    // +1
        check("lk_wen",   32'(bus1.io_write_en), 32'd1);
        check("lk_wdata", 32'(bus1.io_writedata), 32'h0F);
        tick();                                    // +2
        check("lk_ack0_wr", 32'(bus1.ack0), 32'd1);
        bus1.req0 = 0;
        tick();                                    // IDLE, port 1 sampled
        check("lk_p1_idle", 32'(bus1.ack1), 32'd0);
        tick();                                    // port 1 ISSUE
        check("lk_p1_wen",   32'(bus1.io_write_en), 32'd1);
        check("lk_p1_wdata", 32'(bus1.io_writedata), 32'h99);
        tick();
        check("lk_p1_ack1",  32'(bus1.ack1), 32'd1);
        bus1.req1 = 0;
        tick();
`endif

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
